// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the RV32M multiply/divide sequencer
package muldiv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - operand magnitude on entry and final result negation on completion
module muldiv_signfix
  import muldiv_pkg::*;
(
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              a_signed,
  input  logic              b_signed,
  input  logic [2*XLEN-1:0] val,
  input  logic              val_neg,
  output logic [XLEN-1:0]   a_abs,
  output logic [XLEN-1:0]   b_abs,
  output logic              a_neg,
  output logic              b_neg,
  output logic [2*XLEN-1:0] val_fix
);
  assign a_neg   = a_signed & a[XLEN-1];
  assign b_neg   = b_signed & b[XLEN-1];
  // 0x80000000 negates to itself, which is exactly its unsigned magnitude
  assign a_abs   = a_neg ? -a : a;
  assign b_abs   = b_neg ? -b : b;
  assign val_fix = val_neg ? -val : val;
endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M shift-add multiply / restoring divide sequencer
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import muldiv_pkg::*;

  state_e            state, state_nxt;
  op_e               op_q;
  op_e               op_in;
  logic [4:0]        count;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd_b;
  logic              neg_a, neg_b, special;
  logic [XLEN-1:0]   result_q;

  logic              accept;
  logic              in_sign_a, in_sign_b, in_neg_a, in_neg_b;
  logic [XLEN-1:0]   in_a_abs, in_b_abs;
  logic              div_zero, div_ovf, special_in;
  logic [XLEN-1:0]   special_val;

  assign op_in     = op_e'(funct3);
  assign accept    = (state == IDLE) & start & ~flush;
  assign in_sign_a = op_in inside {MULH, MULHSU, DIV, REM};
  assign in_sign_b = op_in inside {MULH, DIV, REM};

  assign div_zero    = op_in[2] & (op_b == '0);
  assign div_ovf     = (op_in == DIV || op_in == REM) & (op_a == 32'h8000_0000) & (op_b == '1);
  assign special_in  = div_zero | div_ovf;
  // overflow: quotient is op_a itself (0x80000000), remainder is zero
  assign special_val = div_zero ? (op_in[1] ? op_a : DIV_ZERO_Q)
                                : (op_in[1] ? '0 : op_a);

  // acc holds {product_hi, multiplier} for multiply, {remainder, dividend/quotient} for divide
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     div_sh, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_nxt;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd_b & {XLEN{acc[0]}}};
  assign mul_nxt  = {mul_sum, acc[XLEN-1:1]};
  assign div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff = div_sh - {1'b0, opnd_b};
  assign div_ge   = div_sh >= {1'b0, opnd_b};
  assign div_nxt  = {div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0], acc[XLEN-2:0], div_ge};

  logic              is_rem;
  logic [XLEN-1:0]   div_sel;
  logic [2*XLEN-1:0] fix_val, fix_out;
  logic              fix_neg;
  logic [XLEN-1:0]   done_val;

  assign is_rem   = op_q[2] & op_q[1];
  assign div_sel  = is_rem ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
  assign fix_val  = op_q[2] ? {{XLEN{1'b0}}, div_sel} : acc;
  assign fix_neg  = is_rem ? neg_a : (neg_a ^ neg_b);
  assign done_val = special ? acc[XLEN-1:0]
                  : (op_q inside {MULH, MULHSU, MULHU}) ? fix_out[2*XLEN-1:XLEN]
                  : fix_out[XLEN-1:0];

  muldiv_signfix u_signfix (
    .a        (op_a),
    .b        (op_b),
    .a_signed (in_sign_a),
    .b_signed (in_sign_b),
    .val      (fix_val),
    .val_neg  (fix_neg),
    .a_abs    (in_a_abs),
    .b_abs    (in_b_abs),
    .a_neg    (in_neg_a),
    .b_neg    (in_neg_b),
    .val_fix  (fix_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special_in ? DONE : CALC;
      CALC:    if (flush) state_nxt = IDLE;
               else if (count == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall  = accept | (state == CALC);
    done   = (state == DONE) & ~flush;
    result = done ? done_val : result_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= MUL;
      count    <= '0;
      acc      <= '0;
      opnd_b   <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      special  <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= op_in;
        neg_a   <= in_neg_a;
        neg_b   <= in_neg_b;
        special <= special_in;
        count   <= '0;
        opnd_b  <= in_b_abs;
        acc     <= {{XLEN{1'b0}}, special_in ? special_val : in_a_abs};
      end else if (state == CALC) begin
        count <= count + 5'd1;
        acc   <= op_q[2] ? div_nxt : mul_nxt;
      end
      if (done) result_q <= done_val;
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed self-checking bench for muldiv_seq
module tb_muldiv_seq;
  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_res;

  muldiv_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int  lat;
    logic stall_ok;
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    #1 chk({tag, "_stall_start"}, {31'b0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    stall_ok = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (stall !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_stall_busy"}, {31'b0, stall_ok}, 32'd1);
    chk({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
    chk({tag, "_result"}, result, exp_res);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    chk({tag, "_result_held"}, result, exp_res);
    last_res = exp_res;
  endtask

  initial begin
    logic saw_done;
    rst = 1'b1; start = 1'b0; funct3 = 3'b000; op_a = '0; op_b = '0; flush = 1'b0;
    last_res = '0;
    #12;
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul_7x6",    3'b000, 32'd7,         32'd6,         32'd42,        33);
    run_op("mulh_m1m1",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("mulhu_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulhsu_m1x2",3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);
    run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    run_op("remu_100_7", 3'b111, 32'd100,       32'd7,         32'd2,         33);
    run_op("divu_5_0",   3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_op("rem_div0",   3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1);

    // DIV flushed at N+10, with an ignored start pulse while calculating
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; op_a = 32'd100; op_b = 32'd3;
    @(negedge clk);
    saw_done = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (done === 1'b1 || stall !== 1'b1) saw_done = 1'b1;
      if (i == 3) begin
        start = 1'b1; funct3 = 3'b101; op_b = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("flush_calc_busy", {31'b0, saw_done}, 32'd0);
    flush = 1'b1;
    #1 chk("flush_stall_same_cycle", {31'b0, stall}, 32'd1);
    chk("flush_done_same_cycle", {31'b0, done}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_stall_after", {31'b0, stall}, 32'd0);
    chk("flush_result_kept", result, last_res);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0 || stall !== 1'b0) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("flush_no_done", {31'b0, saw_done}, 32'd0);
    chk("flush_result_final", result, last_res);

    // asynchronous reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd5; op_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("areset_busy_before", {31'b0, stall}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("areset_stall", {31'b0, stall}, 32'd0);
    chk("areset_done", {31'b0, done}, 32'd0);
    chk("areset_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("mul_3x3_after_reset", 3'b000, 32'd3, 32'd3, 32'd9, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer attached to the execute stage.
- Accepts one M-extension operation per start pulse and runs a 32-iteration shift-add multiply or restoring divide.
- Holds the execute stage via stall until the result is ready.
- Result is muxed into alu_result_EXE by the execute stage on the done cycle.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported, the iteration count equals XLEN.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only in IDLE
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  XLEN  rs1 value after forwarding
- op_b  input  XLEN  rs2 value after forwarding
- flush  input  1  abort current operation (branch/jump redirect)
- stall  output  1  hold IF/ID/EXE pipeline registers
- done  output  1  one-cycle pulse; result valid this cycle
- result  output  XLEN  operation result, held until next accepted start

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (async, any state): state=IDLE, count=0, result=0, done=0, internal accumulators=0.
- IDLE, start=1, flush=0 (cycle N):
  - latch funct3 and sign flags;
  - latch |op_a|, |op_b| per signedness (MULH: both signed; MULHSU: a signed, b unsigned; MULHU/DIVU/REMU: unsigned; DIV/REM: both signed);
  - go to CALC with count=0.
- Special divides bypass CALC (IDLE->DONE, done at N+1):
  - divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> op_a.
  - signed overflow, op_a=0x80000000 and op_b=0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
- CALC: one iteration per cycle, count 0..31; on count=31 go to DONE. Normal latency: done at cycle N+33.
  - Multiply: 64-bit product register, add multiplicand when LSB of multiplier set, shift right.
  - Divide: restoring; shift remainder left, subtract divisor, keep if non-negative, set quotient bit.
- DONE: one cycle; done=1; result driven.
  - Sign correction: negate product if signs differ (signed ops); quotient negated if signs differ; remainder takes dividend sign.
  - MUL -> low 32 bits, MULH* -> high 32 bits.
  - Next state IDLE.
- stall = (state==IDLE & start & ~flush) | (state==CALC). Deasserted in DONE so the pipeline advances capturing result.
- start while CALC/DONE: ignored; no queueing.
- flush in CALC or DONE: next state IDLE, done=0 that cycle and after, result unchanged from previous op.
- start and flush together in IDLE: flush wins, no operation.
- All arithmetic modulo 2^32 on outputs; |0x80000000| handled as unsigned 0x80000000.

Decomposition:
- Shared package muldiv_pkg: funct3 op enum (MUL..REMU), state enum (IDLE/CALC/DONE), XLEN constant, DIV_ZERO_Q constant 0xFFFFFFFF.
- One natural sub-module: muldiv_signfix. It is combinational; it computes abs of inputs and final negation of outputs, and is reused at entry and in DONE.
- The FSM and iteration datapath stay in muldiv_seq.

Test Plan:
- MUL op_a=7, op_b=6, start at N -> stall N..N+32, done=1 only at N+33, result=42.
- MULH op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> result=0x00000000; MULHU same operands -> result=0xFFFFFFFE.
- DIV op_a=-7 (0xFFFFFFF9), op_b=2 -> result 0xFFFFFFFD (-3); REM same -> 0xFFFFFFFF (-1); REMU 100/7 -> 2.
- DIVU op_a=5, op_b=0 -> done at N+1, result 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> done at N+1, result 0x80000000.
- Flush at N+10 of a DIV -> IDLE at N+11, stall low from N+11, no done pulse, result keeps prior value; start while in CALC is ignored.
- Assert rst asynchronously at N+5 mid-MUL -> immediately state IDLE, stall=0, done=0, result=0; new MUL 3*3 after release -> 9 at +33.
